// File: rtl/mask_pkg.sv
// Shared types for the mask segment ROM path.
// Word layout, load sequencing states and unpack helpers.
package mask_pkg;

  localparam int MASK_WORD_BYTES = 5;
  localparam int MASK_WORD_WIDTH = 40;

  typedef struct packed {
    logic [9:0] length;
    logic [9:0] y;
    logic [9:0] start_x;
    logic [9:0] segment_id;
  } mask_word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    DRAINING,
    DONE
  } load_state_t;

  // Byte count after a two-byte strobe, wrapping at one word.
  function automatic logic [2:0] next_byte_cnt(
    input logic [2:0] cnt
  );
    logic [3:0] sum;
    sum = {1'b0, cnt} + 4'd2;
    if (sum >= 4'(MASK_WORD_BYTES))
      sum = sum - 4'(MASK_WORD_BYTES);
    return sum[2:0];
  endfunction

endpackage

// File: rtl/mask_write_fifo.sv
// Pending ROM write queue of {addr, data}.
// Head entry is visible combinationally.
module mask_write_fifo
  import mask_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  mask_word_t    push_data,
  output logic [AW-1:0] head_addr,
  output mask_word_t    head_data,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  mask_word_t    data_mem [DEPTH];

  logic [PW:0] wr_q, wr_d;
  logic [PW:0] rd_q, rd_d;
  logic        do_push;
  logic        do_pop;

  // A full queue still accepts when it pops the same cycle.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[PW] != rd_q[PW]) &&
              (wr_q[PW-1:0] == rd_q[PW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_q[PW-1:0]] <= push_addr;
      data_mem[wr_q[PW-1:0]] <= push_data;
    end
  end

  // Read and write pointers with wrap bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Head of queue straight from storage.
  always_comb begin
    head_addr = addr_mem[rd_q[PW-1:0]];
    head_data = data_mem[rd_q[PW-1:0]];
  end

endmodule

// File: rtl/mask_rom_arbiter.sv
// Single-port mask ROM owner: unpacks the download stream,
// queues words, and gives the video reader priority.
module mask_rom_arbiter
  import mask_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WORDS  = 18720
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ioctl_download,
  input  logic                       ioctl_wr,
  input  logic [15:0]                ioctl_dout,
  input  logic                       rd_req,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic                       rd_valid,
  output logic [MASK_WORD_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]      rom_address,
  output logic                       rom_wren,
  output logic [MASK_WORD_WIDTH-1:0] rom_data,
  input  logic [MASK_WORD_WIDTH-1:0] rom_q,
  output logic                       load_done,
  output logic                       load_error,
  output logic [ADDR_WIDTH-1:0]      words_written
);

  localparam logic [ADDR_WIDTH:0] MAX_W =
    (ADDR_WIDTH+1)'(MAX_WORDS);

  load_state_t state_q, state_d;

  logic                  dl_q;
  logic                  rd_valid_q;
  logic                  err_q, err_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] words_q, words_d;

  logic                  dl_rise;
  logic                  dl_fall;
  logic                  wr_en;
  logic [2:0]            cnt_base;
  logic [ADDR_WIDTH-1:0] waddr_base;
  logic                  word_done;
  mask_word_t            word;
  logic                  in_range;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH-1:0] head_addr;
  mask_word_t            head_data;

  // Download edges; a strobe only counts while downloading.
  always_comb begin
    dl_rise = ioctl_download & ~dl_q;
    dl_fall = ~ioctl_download & dl_q;
    wr_en   = ioctl_wr & ioctl_download;
  end

  // Byte unpacker: two bytes per strobe, low byte first.
  always_comb begin
    cnt_base  = dl_rise ? 3'd0 : cnt_q;
    cnt_d     = cnt_base;
    buf_d     = buf_q;
    word_done = 1'b0;
    word      = '0;
    if (wr_en) begin
      cnt_d = next_byte_cnt(cnt_base);
      unique case (cnt_base)
        3'd0: buf_d[15:0]  = ioctl_dout;
        3'd1: buf_d[23:8]  = ioctl_dout;
        3'd2: buf_d[31:16] = ioctl_dout;
        3'd3: begin
          word      = mask_word_t'({ioctl_dout,
                                    buf_q[23:0]});
          word_done = 1'b1;
        end
        default: begin
          word       = mask_word_t'({ioctl_dout[7:0],
                                     buf_q});
          buf_d[7:0] = ioctl_dout[15:8];
          word_done  = 1'b1;
        end
      endcase
    end
    if (dl_fall)
      cnt_d = 3'd0;
  end

  // Push decision, address advance and error tracking.
  always_comb begin
    waddr_base = dl_rise ? '0 : waddr_q;
    in_range   = {1'b0, waddr_base} < MAX_W;
    pop        = ~rd_req & ~fifo_empty;
    push       = word_done & in_range &
                 (~fifo_full | pop);
    waddr_d    = waddr_base;
    if (word_done & in_range)
      waddr_d = waddr_base + ADDR_WIDTH'(1);
    words_d = words_q;
    if (dl_rise)
      words_d = '0;
    else if (pop)
      words_d = words_q + ADDR_WIDTH'(1);
    err_d = dl_rise ? 1'b0 : err_q;
    if (word_done & ~push)
      err_d = 1'b1;
    if (dl_fall && cnt_q != 3'd0)
      err_d = 1'b1;
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 3'd0;
      buf_q      <= '0;
      waddr_q    <= '0;
      words_q    <= '0;
    end else begin
      dl_q       <= ioctl_download;
      rd_valid_q <= rd_req;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      waddr_q    <= waddr_d;
      words_q    <= words_d;
    end
  end

  mask_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (waddr_base),
    .push_data (word),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Load sequencing state register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Load sequencing transitions; a new download restarts.
  always_comb begin
    state_d = state_q;
    if (dl_rise) begin
      state_d = LOADING;
    end else begin
      unique case (state_q)
        IDLE:     state_d = IDLE;
        LOADING:  if (dl_fall) state_d = DRAINING;
        DRAINING: if (fifo_empty) state_d = DONE;
        DONE:     state_d = DONE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Load sequencing outputs.
  always_comb begin
    load_done = (state_q == DONE);
  end

  // ROM port mux: reads win, otherwise drain one write.
  always_comb begin
    rom_wren      = pop;
    rom_address   = pop ? head_addr : rd_addr;
    rom_data      = head_data;
    rd_valid      = rd_valid_q;
    rd_data       = rom_q;
    load_error    = err_q;
    words_written = words_q;
  end

endmodule

// File: tb/tb_mask_rom_arbiter.sv
// Bench for mask_rom_arbiter: byte-stream reference model
// plus directed scenarios and randomized downloads.
module tb_mask_rom_arbiter;

  localparam int AW    = 15;
  localparam int DEPTH = 4;
  localparam int MAXW  = 18720;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [15:0]   ioctl_dout = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          rd_valid;
  logic [39:0]   rd_data;
  logic [AW-1:0] rom_address;
  logic          rom_wren;
  logic [39:0]   rom_data;
  logic [39:0]   rom_q = '0;
  logic          load_done;
  logic          load_error;
  logic [AW-1:0] words_written;

  logic          rd_valid2;
  logic [39:0]   rd_data2;
  logic [AW-1:0] rom_address2;
  logic          rom_wren2;
  logic [39:0]   rom_data2;
  logic [39:0]   rom_q2 = '0;
  logic          load_done2;
  logic          load_error2;
  logic [AW-1:0] words_written2;

  int n_chk = 0;
  int n_fail = 0;
  bit live = 1'b0;

  always #5 clk = ~clk;

  mask_rom_arbiter #(
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH),
    .MAX_WORDS  (MAXW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rom_address    (rom_address),
    .rom_wren       (rom_wren),
    .rom_data       (rom_data),
    .rom_q          (rom_q),
    .load_done      (load_done),
    .load_error     (load_error),
    .words_written  (words_written)
  );

  mask_rom_arbiter #(
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH),
    .MAX_WORDS  (2)
  ) dut2 (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_valid       (rd_valid2),
    .rd_data        (rd_data2),
    .rom_address    (rom_address2),
    .rom_wren       (rom_wren2),
    .rom_data       (rom_data2),
    .rom_q          (rom_q2),
    .load_done      (load_done2),
    .load_error     (load_error2),
    .words_written  (words_written2)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ROM device: registered read, single port.
  logic [39:0] rom [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++)
      rom[i] = '0;
  end
  always @(posedge clk) begin
    if (rom_wren)
      rom[rom_address] <= rom_data;
    rom_q <= rom[rom_address];
  end

  // Reference model: byte queue, write queue, expected ROM.
  logic [7:0]      pend[$];
  logic [AW+39:0]  mq[$];
  logic [39:0]     mmem[int];
  int              m_waddr = 0;
  int              m_words = 0;
  int              m_phase = 0;
  bit              m_err = 1'b0;
  bit              m_dl = 1'b0;
  bit              m_prev_rd = 1'b0;
  logic [39:0]     m_rd_data = '0;

  always @(posedge clk) begin : model
    bit rise, fall, popn;
    int sz0;
    logic [39:0] w;
    logic [AW+39:0] ent;
    if (reset) begin
      pend.delete();
      mq.delete();
      m_waddr = 0;
      m_words = 0;
      m_phase = 0;
      m_err = 1'b0;
      m_dl = 1'b0;
      m_prev_rd = 1'b0;
    end else begin
      sz0 = mq.size();
      rise = ioctl_download && !m_dl;
      fall = !ioctl_download && m_dl;
      m_prev_rd = rd_req;
      if (rd_req)
        m_rd_data = mmem.exists(int'(rd_addr)) ?
                    mmem[int'(rd_addr)] : 40'h0;
      popn = !rd_req && sz0 > 0;
      if (popn) begin
        ent = mq.pop_front();
        mmem[int'(ent[AW+39:40])] = ent[39:0];
      end
      if (rise) begin
        pend.delete();
        m_waddr = 0;
        m_words = 0;
        m_err = 1'b0;
      end else if (popn) begin
        m_words++;
      end
      if (ioctl_wr && ioctl_download) begin
        pend.push_back(ioctl_dout[7:0]);
        pend.push_back(ioctl_dout[15:8]);
        if (pend.size() >= 5) begin
          w = '0;
          for (int k = 0; k < 5; k++)
            w[8*k +: 8] = pend.pop_front();
          if (m_waddr >= MAXW) begin
            m_err = 1'b1;
          end else begin
            if (mq.size() >= DEPTH)
              m_err = 1'b1;
            else
              mq.push_back({AW'(m_waddr), w});
            m_waddr++;
          end
        end
      end
      if (fall) begin
        if (pend.size() != 0)
          m_err = 1'b1;
        pend.delete();
      end
      if (rise)
        m_phase = 1;
      else if (m_phase == 1 && fall)
        m_phase = 2;
      else if (m_phase == 2 && sz0 == 0)
        m_phase = 3;
      m_dl = ioctl_download;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : compare
    logic [AW+39:0] hd;
    bit ew;
    if (live && !reset) begin
      ew = !rd_req && mq.size() > 0;
      chk("rom_wren", rom_wren, ew);
      if (ew) begin
        hd = mq[0];
        chk("rom_address_wr", rom_address, hd[AW+39:40]);
        chk("rom_data", rom_data, hd[39:0]);
      end else begin
        chk("rom_address_rd", rom_address, rd_addr);
      end
      chk("rd_valid", rd_valid, m_prev_rd);
      if (m_prev_rd)
        chk("rd_data", rd_data, m_rd_data);
      chk("load_done", load_done, m_phase == 3);
      chk("load_error", load_error, m_err);
      chk("words_written", words_written, m_words);
      if (rom_wren2)
        chk("max_words_addr", rom_address2 < 2, 1'b1);
    end
  end

  logic [AW+39:0] wlog[$];
  always @(negedge clk) begin
    if (live && !reset && rom_wren)
      wlog.push_back({rom_address, rom_data});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] d);
    ioctl_wr = 1'b1;
    ioctl_dout = d;
    cyc();
    ioctl_wr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pr;
    int n;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    live = 1'b1;
    @(negedge clk);
    chk("reset_rom_wren", rom_wren, 1'b0);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_load_done", load_done, 1'b0);
    chk("reset_load_error", load_error, 1'b0);
    chk("reset_words", words_written, 0);
    cyc();

    // Two full words, no reads.
    wlog.delete();
    ioctl_download = 1'b1;
    strobe(16'h2211);
    strobe(16'h4433);
    strobe(16'h6655);
    strobe(16'h8877);
    strobe(16'hAA99);
    ioctl_download = 1'b0;
    cyc();
    chk("t1_done_early", load_done, 1'b0);
    cyc();
    chk("t1_done", load_done, 1'b1);
    chk("t1_words", words_written, 2);
    chk("t1_error", load_error, 1'b0);
    chk("t1_nwrites", wlog.size(), 2);
    chk("t1_word0", wlog[0], {15'd0, 40'h5544332211});
    chk("t1_word1", wlog[1], {15'd1, 40'hAA99887766});

    // Reader holds the port through a 3-strobe download.
    wlog.delete();
    rd_addr = AW'(7);
    rd_req = 1'b1;
    cyc();
    ioctl_download = 1'b1;
    strobe(16'h0201);
    strobe(16'h0403);
    strobe(16'h0605);
    ioctl_download = 1'b0;
    cyc();
    cyc();
    chk("t2_rd_valid", rd_valid, 1'b1);
    chk("t2_no_write", wlog.size(), 0);
    rd_req = 1'b0;
    @(negedge clk);
    chk("t2_commit_wren", rom_wren, 1'b1);
    chk("t2_commit_addr", rom_address, 0);
    chk("t2_commit_data", rom_data, 40'h0504030201);
    cyc();
    cyc();
    chk("t2_done", load_done, 1'b1);
    chk("t2_error", load_error, 1'b1);
    chk("t2_words", words_written, 1);

    // Overflow while the reader starves the writes.
    wlog.delete();
    rd_addr = AW'(3);
    rd_req = 1'b1;
    ioctl_download = 1'b1;
    for (int i = 0; i < (2*DEPTH+2)*5/2; i++)
      strobe(16'($urandom));
    ioctl_download = 1'b0;
    cyc();
    cyc();
    rd_req = 1'b0;
    repeat (DEPTH + 3) cyc();
    chk("t3_commits", wlog.size(), DEPTH);
    chk("t3_words", words_written, DEPTH);
    chk("t3_error", load_error, 1'b1);
    chk("t3_done", load_done, 1'b1);

    // Reset with two words still queued.
    rd_req = 1'b1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 5; i++)
      strobe(16'($urandom));
    cyc();
    reset = 1'b1;
    ioctl_download = 1'b0;
    cyc();
    reset = 1'b0;
    rd_req = 1'b0;
    wlog.delete();
    @(negedge clk);
    chk("t4_wren", rom_wren, 1'b0);
    chk("t4_done", load_done, 1'b0);
    chk("t4_words", words_written, 0);
    repeat (8) cyc();
    chk("t4_no_writes", wlog.size(), 0);

    // Capacity limit on the MAX_WORDS=2 instance.
    ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++)
      strobe(16'($urandom));
    ioctl_download = 1'b0;
    repeat (6) cyc();
    chk("t5_words", words_written2, 2);
    chk("t5_error", load_error2, 1'b1);
    chk("t5_done", load_done2, 1'b1);

    // Randomized downloads with contending reads.
    for (int d = 0; d < 25; d++) begin
      pr = $urandom_range(0, 90);
      n = $urandom_range(0, 30);
      ioctl_download = 1'b1;
      for (int k = 0; k < n; k++) begin
        rd_req = ($urandom_range(0, 99) < pr);
        rd_addr = AW'($urandom_range(0, 15));
        ioctl_wr = ($urandom_range(0, 99) < 60);
        ioctl_dout = 16'($urandom);
        reset = ($urandom_range(0, 199) == 0);
        cyc();
      end
      reset = 1'b0;
      ioctl_download = 1'b0;
      for (int k = 0; k < 12; k++) begin
        rd_req = ($urandom_range(0, 199) < pr);
        rd_addr = AW'($urandom_range(0, 15));
        ioctl_wr = ($urandom_range(0, 99) < 20);
        ioctl_dout = 16'($urandom);
        cyc();
      end
      ioctl_wr = 1'b0;
    end
    rd_req = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mask_rom_arbiter.md
Name: mask_rom_arbiter

Overview:
- Owns the single port of the mask segment ROM.
- Unpacks the 16-bit ioctl download stream into 40-bit mask words and queues them in a small write FIFO.
- Shares the ROM port between that write queue and the video-side segment reader; reads always win.
- Sits between the HPS download path and the mask pixel selector; reports load completion and error status.

Parameters:
- ADDR_WIDTH, 15, ROM word address width.
- FIFO_DEPTH, 4, pending-write FIFO entries; power of two, at least 2.
- MAX_WORDS, 18720, ROM capacity in words; writes at or beyond this are dropped.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high for the duration of a mask download.
- ioctl_wr  in  1  one-cycle strobe; ioctl_dout valid.
- ioctl_dout  in  16  two bytes; low byte is first in stream order.
- rd_req  in  1  video reader requests rd_addr this cycle.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_valid  out  1  rd_data valid; exactly 1 cycle after an rd_req.
- rd_data  out  40  ROM read data (passes through rom_q).
- rom_address  out  ADDR_WIDTH  ROM address, combinational mux.
- rom_wren  out  1  ROM write enable.
- rom_data  out  40  ROM write data.
- rom_q  in  40  ROM output, registered inside the ROM (1-cycle latency).
- load_done  out  1  download finished and all words committed.
- load_error  out  1  sticky: overflow, capacity exceeded or partial final word.
- words_written  out  ADDR_WIDTH  words committed during current/last download.

Behaviour:
- Reset: FIFO empty; byte count 0; write address 0. rd_valid, rom_wren, load_done and load_error are 0. words_written is 0.
- Unpacker:
  - Byte count is 0..4; byte k of a word goes to bits [8k+7:8k].
  - Each ioctl_wr consumes both bytes in that cycle: the low byte first, then the high byte.
  - If count==4 on arrival, the low byte completes the word and the high byte becomes byte 0 of the next word. Next count is (count+2) mod 5.
  - At most one word completes per strobe.
  - A completed word is pushed to the FIFO with address = write address; the write address then increments.
- Push rules:
  - FIFO full at completion: word dropped, address still increments, load_error set.
  - Address >= MAX_WORDS: word dropped, load_error set.
  - ioctl_wr while ioctl_download is low is ignored.
- Arbitration (combinational, per cycle):
  - rd_req=1: rom_address=rd_addr, rom_wren=0, and rd_valid=1 on the next cycle.
  - Otherwise, if the FIFO is non-empty: pop head, rom_address=head addr, rom_data=head data, rom_wren=1, and increment words_written.
  - Otherwise: rom_address=rd_addr, rom_wren=0.
- Push and pop in the same cycle are legal; occupancy is unchanged. A push into a full FIFO that is popping that same cycle is accepted.
- The reader never stalls. Writes can starve indefinitely under continuous rd_req; the FIFO absorbs this, and overflow is reported, not backpressured.
- Download sequencing FSM, states IDLE, LOADING, DRAINING, DONE:
  - IDLE to LOADING on the rising edge of ioctl_download. Clear byte count, write address, words_written, load_done and load_error. The FIFO is not flushed.
  - LOADING to DRAINING on the falling edge of ioctl_download. If byte count != 0, discard the partial word and set load_error.
  - DRAINING to DONE when the FIFO is empty.
  - DONE: load_done=1.
  - Any state: a rising edge of ioctl_download restarts LOADING.
- reset mid-download: all state returns to reset values. Queued words are lost and load_done stays 0 until a new complete download.
- The rising edge of ioctl_download and an ioctl_wr in the same cycle: the write counts as the first bytes of the new download.

Decomposition:
- Shared package mask_pkg:
  - MASK_WORD_BYTES=5, MASK_WORD_WIDTH=40.
  - mask_word_t, a packed struct {length[9:0], y[9:0], start_x[9:0], segment_id[9:0]}, MSB to LSB.
  - load_state_t enum.
- One sub-module, mask_write_fifo: synchronous FIFO of {addr, data}.
  - Ports: push, pop, full, empty.
  - Registered read-out is not allowed; head data is available combinationally.

Test Plan:
- Download 5 strobes with data 0x2211, 0x4433, 0x6655, 0x8877, 0xAA99, no rd_req:
  - Word 0 written = 0x5544332211.
  - Word 1 written = 0xAA99887766.
  - load_done=1 two cycles after ioctl_download falls; words_written=2; load_error=0.
- Hold rd_req high with rd_addr=7 throughout a 3-strobe download, then release:
  - rom_wren stays 0 while rd_req is high.
  - rd_valid=1 every cycle from the second onward.
  - One word commits on the first cycle rd_req is low.
- rd_req held continuously while 2*FIFO_DEPTH+2 words stream in:
  - Exactly FIFO_DEPTH words are committed after release.
  - load_error=1; words_written=FIFO_DEPTH.
- Download of 3 strobes (6 bytes): word 0 committed; trailing byte discarded; load_error=1; load_done=1.
- Assert reset during LOADING with 2 words queued: next cycle rom_wren=0, load_done=0, words_written=0, and no queued write ever appears.
- MAX_WORDS=2 with a 3-word download: address 2 is never written; load_error=1; words_written=2.
